// File: rtl/spdif_rx_buffer.sv
// SPDIF receive sample buffer: pairs channel A/B subframes into 64-bit words and
// stores them in a ping-pong dual-port RAM that the DMA controller drains.
module spdif_rx_buffer #(
   parameter int DMA_DWIDTH = 64,
   parameter int DMA_AWIDTH = 12
) (
   input  logic                  clk_i,
   input  logic                  rst_i,
   input  logic                  enable_i,
   input  logic                  rx_valid_i,
   input  logic                  rx_chan_i,
   input  logic [23:0]           rx_sample_i,
   input  logic                  rx_blk_i,
   input  logic                  rx_perr_i,
   input  logic                  dma_en_i,
   input  logic                  dma_we_i,
   input  logic [DMA_AWIDTH-1:0] dma_adr_i,
   input  logic [DMA_DWIDTH-1:0] dma_dat_i,
   output logic [DMA_DWIDTH-1:0] dma_dat_o,
   input  logic                  irq_ack_i,
   input  logic                  clr_err_i,
   output logic                  half_irq_o,
   output logic                  half_o,
   output logic                  pending_o,
   output logic                  overrun_o,
   output logic                  sync_err_o,
   output logic [DMA_AWIDTH-1:0] wr_ptr_o
);

   localparam int DEPTH = 1 << DMA_AWIDTH;
   localparam logic [0:0] WAIT_A = 1'b0;
   localparam logic [0:0] WAIT_B = 1'b1;

   function automatic logic [63:0] pack_word(input logic blk_a, input logic perr_a,
                                             input logic perr_b, input logic [23:0] smp_a,
                                             input logic [23:0] smp_b);
      pack_word = {blk_a, perr_a, perr_b, 5'b00000, smp_a, 8'h00, smp_b};
   endfunction

   logic [DMA_DWIDTH-1:0] mem_r [DEPTH];
   logic [0:0]            state_r;
   logic [23:0]           a_sample_r;
   logic                  a_blk_r;
   logic                  a_perr_r;
   logic [DMA_AWIDTH-1:0] wr_ptr_r;
   logic [DMA_DWIDTH-1:0] dma_dat_r;
   logic                  half_irq_r;
   logic                  half_r;
   logic                  pending_r;
   logic                  overrun_r;
   logic                  sync_err_r;

   logic [0:0]            state_nxt_s;
   logic                  a_load_s;
   logic                  wr_en_s;
   logic                  sync_set_s;
   logic                  half_done_s;
   logic                  overrun_set_s;
   logic                  dma_wr_s;
   logic [DMA_DWIDTH-1:0] word_s;

   // Subframe pairing FSM decode
   always_comb begin
      state_nxt_s = state_r;
      a_load_s    = 1'b0;
      wr_en_s     = 1'b0;
      sync_set_s  = 1'b0;
      if (!enable_i) begin
         state_nxt_s = WAIT_A;
      end else if (rx_valid_i) begin
         case (state_r)
            WAIT_A: begin
               if (!rx_chan_i) begin
                  a_load_s    = 1'b1;
                  state_nxt_s = WAIT_B;
               end else begin
                  sync_set_s  = 1'b1;
               end
            end
            WAIT_B: begin
               if (rx_chan_i) begin
                  wr_en_s     = 1'b1;
                  state_nxt_s = WAIT_A;
               end else begin
                  // a second A replaces the stale one
                  a_load_s    = 1'b1;
                  sync_set_s  = 1'b1;
               end
            end
            default: begin
               state_nxt_s = WAIT_A;
            end
         endcase
      end else begin
         state_nxt_s = state_r;
      end
   end

   // Word assembly, half-completion and collision decode
   always_comb begin
      word_s        = pack_word(a_blk_r, a_perr_r, rx_perr_i, a_sample_r, rx_sample_i);
      half_done_s   = wr_en_s & (&wr_ptr_r[DMA_AWIDTH-2:0]);
      overrun_set_s = half_done_s & pending_r & ~irq_ack_i;
      dma_wr_s      = dma_en_i & dma_we_i & ~(wr_en_s && (dma_adr_i == wr_ptr_r));
   end

   // Control and status registers
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_r    <= WAIT_A;
         a_sample_r <= 24'h000000;
         a_blk_r    <= 1'b0;
         a_perr_r   <= 1'b0;
         wr_ptr_r   <= {DMA_AWIDTH{1'b0}};
         half_irq_r <= 1'b0;
         half_r     <= 1'b0;
         pending_r  <= 1'b0;
         overrun_r  <= 1'b0;
         sync_err_r <= 1'b0;
      end else begin
         state_r    <= state_nxt_s;
         half_irq_r <= half_done_s;
         if (a_load_s) begin
            a_sample_r <= rx_sample_i;
            a_blk_r    <= rx_blk_i;
            a_perr_r   <= rx_perr_i;
         end
         if (wr_en_s) begin
            wr_ptr_r <= wr_ptr_r + {{(DMA_AWIDTH-1){1'b0}}, 1'b1};
         end
         if (half_done_s) begin
            half_r    <= wr_ptr_r[DMA_AWIDTH-1];
            pending_r <= 1'b1;
         end else if (irq_ack_i) begin
            pending_r <= 1'b0;
         end
         if (overrun_set_s) begin
            overrun_r <= 1'b1;
         end else if (clr_err_i) begin
            overrun_r <= 1'b0;
         end
         if (sync_set_s) begin
            sync_err_r <= 1'b1;
         end else if (clr_err_i) begin
            sync_err_r <= 1'b0;
         end
      end
   end

   // Sample RAM: receiver port has priority over a DMA write to the same word
   always_ff @(posedge clk_i) begin
      if (wr_en_s) begin
         mem_r[wr_ptr_r] <= word_s;
      end
      if (dma_wr_s) begin
         mem_r[dma_adr_i] <= dma_dat_i;
      end
   end

   // DMA read port, one-cycle latency, holds between reads
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         dma_dat_r <= {DMA_DWIDTH{1'b0}};
      end else if (dma_en_i && !dma_we_i) begin
         dma_dat_r <= mem_r[dma_adr_i];
      end
   end

   assign dma_dat_o  = dma_dat_r;
   assign half_irq_o = half_irq_r;
   assign half_o     = half_r;
   assign pending_o  = pending_r;
   assign overrun_o  = overrun_r;
   assign sync_err_o = sync_err_r;
   assign wr_ptr_o   = wr_ptr_r;

endmodule

// File: tb/tb_spdif_rx_buffer.sv
// Directed bench for spdif_rx_buffer with a 16-word RAM (8-word halves).
module tb_spdif_rx_buffer;

   localparam int AW = 4;
   localparam int DW = 64;

   logic          clk = 1'b0;
   logic          rst_i = 1'b1;
   logic          enable_i = 1'b0;
   logic          rx_valid_i = 1'b0;
   logic          rx_chan_i = 1'b0;
   logic [23:0]   rx_sample_i = 24'h0;
   logic          rx_blk_i = 1'b0;
   logic          rx_perr_i = 1'b0;
   logic          dma_en_i = 1'b0;
   logic          dma_we_i = 1'b0;
   logic [AW-1:0] dma_adr_i = '0;
   logic [DW-1:0] dma_dat_i = '0;
   logic [DW-1:0] dma_dat_o;
   logic          irq_ack_i = 1'b0;
   logic          clr_err_i = 1'b0;
   logic          half_irq_o;
   logic          half_o;
   logic          pending_o;
   logic          overrun_o;
   logic          sync_err_o;
   logic [AW-1:0] wr_ptr_o;

   int total = 0;
   int bad = 0;
   int irq_cnt = 0;
   logic [63:0] rd;

   spdif_rx_buffer #(.DMA_DWIDTH(DW), .DMA_AWIDTH(AW)) dut (
      .clk_i(clk), .rst_i(rst_i), .enable_i(enable_i),
      .rx_valid_i(rx_valid_i), .rx_chan_i(rx_chan_i), .rx_sample_i(rx_sample_i),
      .rx_blk_i(rx_blk_i), .rx_perr_i(rx_perr_i),
      .dma_en_i(dma_en_i), .dma_we_i(dma_we_i), .dma_adr_i(dma_adr_i),
      .dma_dat_i(dma_dat_i), .dma_dat_o(dma_dat_o),
      .irq_ack_i(irq_ack_i), .clr_err_i(clr_err_i),
      .half_irq_o(half_irq_o), .half_o(half_o), .pending_o(pending_o),
      .overrun_o(overrun_o), .sync_err_o(sync_err_o), .wr_ptr_o(wr_ptr_o)
   );

   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (half_irq_o) irq_cnt <= irq_cnt + 1;
   end

   typedef struct {
      logic [23:0] a;
      logic [23:0] b;
      logic [63:0] exp;
   } vec_t;
   vec_t tbl [8];

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      total = total + 1;
      if (act !== exp) begin
         bad = bad + 1;
         $display("FAIL %s: got %h want %h", name, act, exp);
      end
   endtask

   // all stimulus tasks start and end on a falling edge
   task automatic sub(input logic ch, input logic [23:0] s, input logic blk, input logic perr);
      rx_valid_i = 1'b1; rx_chan_i = ch; rx_sample_i = s; rx_blk_i = blk; rx_perr_i = perr;
      @(negedge clk);
      rx_valid_i = 1'b0; rx_blk_i = 1'b0; rx_perr_i = 1'b0;
   endtask

   task automatic pair(input logic [23:0] a, input logic [23:0] b);
      sub(1'b0, a, 1'b0, 1'b0);
      sub(1'b1, b, 1'b0, 1'b0);
   endtask

   task automatic dma_read(input logic [AW-1:0] adr, output logic [63:0] d);
      dma_en_i = 1'b1; dma_we_i = 1'b0; dma_adr_i = adr;
      @(negedge clk);
      dma_en_i = 1'b0;
      d = dma_dat_o;
   endtask

   task automatic dma_write(input logic [AW-1:0] adr, input logic [63:0] d);
      dma_en_i = 1'b1; dma_we_i = 1'b1; dma_adr_i = adr; dma_dat_i = d;
      @(negedge clk);
      dma_en_i = 1'b0; dma_we_i = 1'b0;
   endtask

   task automatic pulse_ack();
      irq_ack_i = 1'b1;
      @(negedge clk);
      irq_ack_i = 1'b0;
   endtask

   task automatic pulse_clr();
      clr_err_i = 1'b1;
      @(negedge clk);
      clr_err_i = 1'b0;
   endtask

   initial begin
      tbl[0] = '{24'h000100, 24'h800000, 64'h00000100_00800000};
      tbl[1] = '{24'h000101, 24'h800001, 64'h00000101_00800001};
      tbl[2] = '{24'h000102, 24'h800002, 64'h00000102_00800002};
      tbl[3] = '{24'h000103, 24'h800003, 64'h00000103_00800003};
      tbl[4] = '{24'h000104, 24'h800004, 64'h00000104_00800004};
      tbl[5] = '{24'h000105, 24'h800005, 64'h00000105_00800005};
      tbl[6] = '{24'h000106, 24'h800006, 64'h00000106_00800006};
      tbl[7] = '{24'h000107, 24'h800007, 64'h00000107_00800007};

      repeat (3) @(negedge clk);
      check("rst_dat", dma_dat_o, 64'h0);
      check("rst_irq", {63'h0, half_irq_o}, 64'h0);
      check("rst_half", {63'h0, half_o}, 64'h0);
      check("rst_pend", {63'h0, pending_o}, 64'h0);
      check("rst_ovr", {63'h0, overrun_o}, 64'h0);
      check("rst_sync", {63'h0, sync_err_o}, 64'h0);
      check("rst_ptr", {60'h0, wr_ptr_o}, 64'h0);
      rst_i = 1'b0;
      enable_i = 1'b1;
      @(negedge clk);

      // first half from the vector table
      for (int i = 0; i < 8; i++) pair(tbl[i].a, tbl[i].b);
      @(negedge clk);
      check("h0_ptr", {60'h0, wr_ptr_o}, 64'd8);
      check("h0_sync", {63'h0, sync_err_o}, 64'h0);
      check("h0_irqcnt", irq_cnt, 64'd1);
      check("h0_half", {63'h0, half_o}, 64'h0);
      check("h0_pend", {63'h0, pending_o}, 64'h1);
      for (int i = 0; i < 8; i++) begin
         dma_read(i[AW-1:0], rd);
         check($sformatf("ram%0d", i), rd, tbl[i].exp);
      end
      @(negedge clk);
      check("dat_hold", dma_dat_o, 64'h00000107_00800007);

      pulse_ack();
      check("ack_pend", {63'h0, pending_o}, 64'h0);

      // second half, pointer wraps
      for (int i = 0; i < 8; i++) pair(24'h000200 + 24'(i), 24'h900000 + 24'(i));
      @(negedge clk);
      check("h1_irqcnt", irq_cnt, 64'd2);
      check("h1_half", {63'h0, half_o}, 64'h1);
      check("h1_pend", {63'h0, pending_o}, 64'h1);
      check("h1_ptr", {60'h0, wr_ptr_o}, 64'h0);
      check("h1_ovr", {63'h0, overrun_o}, 64'h0);
      dma_read(4'd8, rd);
      check("ram8", rd, 64'h00000200_00900000);

      // no ack: next completion overruns
      for (int i = 0; i < 8; i++) pair(24'h000300 + 24'(i), 24'hA00000 + 24'(i));
      @(negedge clk);
      check("ov_irqcnt", irq_cnt, 64'd3);
      check("ov_half", {63'h0, half_o}, 64'h0);
      check("ov_ovr", {63'h0, overrun_o}, 64'h1);
      pulse_clr();
      check("ov_clr", {63'h0, overrun_o}, 64'h0);
      check("ov_pend", {63'h0, pending_o}, 64'h1);
      pulse_ack();

      // A,A,B
      sub(1'b0, 24'h111111, 1'b0, 1'b0);
      sub(1'b0, 24'h222222, 1'b0, 1'b0);
      sub(1'b1, 24'h333333, 1'b0, 1'b0);
      check("aab_sync", {63'h0, sync_err_o}, 64'h1);
      check("aab_ptr", {60'h0, wr_ptr_o}, 64'd9);
      dma_read(4'd8, rd);
      check("aab_word", rd, 64'h00222222_00333333);
      pulse_clr();
      check("sync_clr", {63'h0, sync_err_o}, 64'h0);

      // B,A,B
      sub(1'b1, 24'h444444, 1'b0, 1'b0);
      check("bab_sync", {63'h0, sync_err_o}, 64'h1);
      pair(24'h555555, 24'h666666);
      check("bab_ptr", {60'h0, wr_ptr_o}, 64'd10);
      dma_read(4'd9, rd);
      check("bab_word", rd, 64'h00555555_00666666);
      pulse_clr();

      // flag bits
      sub(1'b0, 24'h0ABCDE, 1'b1, 1'b0);
      sub(1'b1, 24'h012345, 1'b0, 1'b1);
      dma_read(4'd10, rd);
      check("flag_word", rd, 64'hA00ABCDE_00012345);

      // DMA read of the word being written returns old data
      sub(1'b0, 24'h777777, 1'b0, 1'b0);
      rx_valid_i = 1'b1; rx_chan_i = 1'b1; rx_sample_i = 24'h888888;
      dma_en_i = 1'b1; dma_we_i = 1'b0; dma_adr_i = 4'd11;
      @(negedge clk);
      rx_valid_i = 1'b0; dma_en_i = 1'b0;
      check("coll_old", dma_dat_o, 64'h00000203_00900003);
      dma_read(4'd11, rd);
      check("coll_new", rd, 64'h00777777_00888888);

      // DMA write to the word being written is dropped
      sub(1'b0, 24'h0A0A0A, 1'b0, 1'b0);
      rx_valid_i = 1'b1; rx_chan_i = 1'b1; rx_sample_i = 24'h0B0B0B;
      dma_en_i = 1'b1; dma_we_i = 1'b1; dma_adr_i = 4'd12; dma_dat_i = 64'hDEADBEEF_DEADBEEF;
      @(negedge clk);
      rx_valid_i = 1'b0; dma_en_i = 1'b0; dma_we_i = 1'b0;
      dma_read(4'd12, rd);
      check("coll_wr", rd, 64'h000A0A0A_000B0B0B);
      dma_write(4'd13, 64'h01234567_89ABCDEF);
      dma_read(4'd13, rd);
      check("dma_wr", rd, 64'h01234567_89ABCDEF);

      // disabled: nothing written
      enable_i = 1'b0;
      pair(24'h999999, 24'h999999);
      check("dis_ptr", {60'h0, wr_ptr_o}, 64'd13);
      enable_i = 1'b1;

      // reset mid-pair discards latched A
      sub(1'b0, 24'h121212, 1'b0, 1'b0);
      rst_i = 1'b1;
      @(negedge clk);
      rst_i = 1'b0;
      check("mr_ptr", {60'h0, wr_ptr_o}, 64'h0);
      check("mr_pend", {63'h0, pending_o}, 64'h0);
      sub(1'b1, 24'h343434, 1'b0, 1'b0);
      check("mr_sync", {63'h0, sync_err_o}, 64'h1);
      check("mr_ptr2", {60'h0, wr_ptr_o}, 64'h0);
      pair(24'h565656, 24'h787878);
      dma_read(4'd0, rd);
      check("mr_word", rd, 64'h00565656_00787878);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
